// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin mux arbiter.
// The optional hold-lock feature is selected by the ARB_LOCK_EN macro in the top module.
package arb_pkg;

  localparam int ARB_N        = 8;
  localparam int ARB_SEL_W    = 3;
  localparam int ARB_W        = 8;
  localparam int ARB_MAX_HOLD = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [ARB_N-1:0] onehot8(input logic [ARB_SEL_W-1:0] idx);
    onehot8 = ARB_N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Rotating priority encoder: finds the first set request at or after start, wrapping 7 -> 0.
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_SEL_W-1:0] start,
  output logic                 found,
  output logic [ARB_SEL_W-1:0] idx
);

  logic [ARB_SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      cand = start + ARB_SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter_8.sv
// Round-robin arbiter driving an 8:1 word mux with a bounded hold time per grant.
// Define ARB_LOCK_EN to add a lock input that freezes hold expiry for atomic bursts.
module rr_mux_arbiter_8
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int SEL_W    = ARB_SEL_W,
  parameter int W        = ARB_W,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   in_data,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic [W-1:0]     out_data
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  // Handshake: req[k] is a level held until served; gnt[k] (with valid) is the
  // acknowledge, and the requester owns the mux while both are high.
  state_t           state, nxt_state;
  logic [SEL_W-1:0] ptr, nxt_ptr;
  logic [HW-1:0]    hold_cnt, nxt_hold;
  logic [N-1:0]     nxt_gnt;
  logic [SEL_W-1:0] nxt_sel;
  logic             nxt_valid;

  logic             release_g, expire_g, locked;
  logic [N-1:0]     pick_req;
  logic [SEL_W-1:0] pick_start;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

`ifdef ARB_LOCK_EN
  assign locked = lock;
`else
  assign locked = 1'b0;
`endif

  // One encoder serves both states: IDLE searches from ptr, GRANT from the slot after g.
  always_comb begin
    release_g  = 1'b0;
    expire_g   = 1'b0;
    if (state == ST_GRANT) begin
      release_g = !req[sel];
      expire_g  = req[sel] && (hold_cnt == HOLD_LAST) && !locked;
    end
    pick_req   = release_g ? (req & ~gnt) : req;
    pick_start = (state == ST_GRANT) ? sel + SEL_W'(1) : ptr;
  end

  rr_pick_8 u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      valid    <= 1'b0;
    end else begin
      state    <= nxt_state;
      ptr      <= nxt_ptr;
      hold_cnt <= nxt_hold;
      gnt      <= nxt_gnt;
      sel      <= nxt_sel;
      valid    <= nxt_valid;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_hold  = hold_cnt;
    nxt_gnt   = gnt;
    nxt_sel   = sel;
    nxt_valid = valid;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          nxt_state = ST_GRANT;
          nxt_gnt   = onehot8(pick_idx);
          nxt_sel   = pick_idx;
          nxt_valid = 1'b1;
          nxt_hold  = '0;
        end else begin
          nxt_gnt   = '0;
          nxt_valid = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_g || expire_g) begin
          nxt_ptr = sel + SEL_W'(1);
          // On expiry g is always found, at worst as the last candidate.
          if (pick_found) begin
            nxt_gnt   = onehot8(pick_idx);
            nxt_sel   = pick_idx;
            nxt_valid = 1'b1;
            nxt_hold  = '0;
          end else begin
            nxt_state = ST_IDLE;
            nxt_gnt   = '0;
            nxt_valid = 1'b0;
            nxt_hold  = '0;
          end
        end else if (!locked) begin
          nxt_hold = hold_cnt + HW'(1);
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_gnt   = '0;
        nxt_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    out_data = '0;
    if (valid) out_data = in_data[sel*W +: W];
  end

endmodule

// File: doc/rr_mux_arbiter_8.md
Name: rr_mux_arbiter_8

Overview:
- Round-robin arbiter/scheduler that shares one 8:1 word-wide selector datapath among 8 requesters.
- Grants one requester at a time and drives the mux select, a one-hot grant and a valid.
- Enforces a maximum hold time so that no requester starves the others.
- Sits between requesting sources and the downstream consumer of the selected word.

Parameters:
- N, 8, number of requesters; fixed at 8 (select is 3 bits).
- SEL_W, 3, select width, equal to log2(N).
- W, 8, data word width per requester.
- MAX_HOLD, 4, maximum consecutive cycles a grant is held while other requests pend; must be ≥ 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request per requester; level-sensitive, held until served.
- in_data  input  N*W  requester words; requester k occupies bits [k*W +: W].
- gnt  output  N  one-hot grant, registered; all zeros when idle.
- sel  output  SEL_W  registered index of the current grantee; drives the mux select.
- valid  output  1  registered; high while a grant is active.
- out_data  output  W  combinational: in_data[sel*W +: W] when valid, else 0.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: gnt=0, sel=0, valid=0, out_data=0, priority pointer ptr=0, hold_cnt=0, state=IDLE.
- Reset asserted mid-grant drops gnt and valid on the next edge. No request is remembered across reset.
- Arbitration:
  - Search req starting at index ptr and ascending with wrap (ptr, ptr+1, …, 7, 0, …).
  - The first set bit wins.
- State IDLE:
  - If |req is 1, register the winner: gnt=onehot(win), sel=win, valid=1, hold_cnt=0; go to GRANT.
  - Latency from req to gnt is 1 cycle.
  - Otherwise stay in IDLE with all outputs 0.
- State GRANT, evaluated each cycle on the current grantee g=sel:
  - Release: req[g]==0. Set ptr=(g+1) mod 8 and arbitrate the remaining requests from ptr. If there is a winner, switch gnt/sel at the next edge with no idle cycle and set hold_cnt=0. If there is none, go to IDLE with gnt=0 and valid=0.
  - Expiry: req[g]==1 and hold_cnt==MAX_HOLD-1. Set ptr=(g+1) mod 8 and arbitrate from ptr; g is eligible again only after all others. If g is the only requester, it is re-granted with no gap and hold_cnt=0.
  - Otherwise: stay in GRANT and increment hold_cnt.
- Requests that rise while another requester is granted only wait; they do not preempt.
- Invariants:
  - gnt is never multi-hot.
  - gnt==0 exactly when valid==0.
  - sel is left unchanged when entering IDLE; out_data is gated by valid.
- Pointer wrap: the index after 7 is 0.
- Simultaneous release and new request on the same cycle: the new request participates in that cycle's arbitration.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined: adds input port lock (1 bit). While in GRANT with lock==1, hold_cnt is frozen and expiry is suppressed, so the grant persists until req[g] drops (used for atomic multi-word transfers). lock is ignored in IDLE.
- Undefined: there is no lock port, and hold expiry always applies.

Decomposition:
- Package arb_pkg:
  - N, SEL_W, W defaults.
  - State encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - MAX_HOLD default.
- Sub-module rr_pick_8 (purely combinational):
  - Inputs: req[7:0], start[2:0].
  - Outputs: found, idx[2:0], using a rotating priority encoder.
  - Used once for both IDLE and GRANT arbitration, with the masked request vector (current grantee excluded on release).

Test Plan:
- Reset mid-grant: req=8'h04 for 3 cycles, then rst=1 for 1 cycle → next cycle gnt=0, valid=0, sel=0; after rst drops with req=8'h04, gnt=8'h04 one cycle later.
- Single request: req=8'h20 from cycle 0 → cycle 1 gnt=8'h20, sel=5, valid=1, out_data=in_data[47:40]; after req drops → gnt=0 on the next cycle.
- Rotation: req=8'hFF held, MAX_HOLD=4 → grants 0,1,2,…,7,0 in sequence, each lasting exactly 4 cycles, with no gap between grants.
- Release handoff: grant on 2, req=8'h84, req[2] drops → next cycle gnt=8'h80 (sel=7); when it is released, the next grant wraps to index 0 if req[0] is set.
- Lone long requester: req=8'h01 for 10 cycles → gnt=8'h01 continuously, with hold_cnt reloading every 4 cycles and valid never dropping.
- ARB_LOCK_EN defined: req=8'h03, grant on 0, lock=1 for 9 cycles → gnt stays 8'h01 for all 9 cycles; after lock=0, expiry occurs within MAX_HOLD cycles and the grant moves to 1.
